// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory-port arbiter.
//   gnt_t        : bus owner encoding (none / stimulus reader / result checker)
//   DEF_*        : default widths and limits used by mem_arbiter and its interface
//   other_master : the master opposite to a given owner
package mem_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_STIM  = 2'd1,
        GNT_CHECK = 2'd2
    } gnt_t;

    localparam int unsigned DEF_ADDR_WIDTH  = 20;
    localparam int unsigned DEF_DATA_WIDTH  = 16;
    localparam int unsigned DEF_BE_WIDTH    = DEF_DATA_WIDTH / 8;
    localparam int unsigned DEF_MAX_PENDING = 4;
    localparam int unsigned DEF_HOLD_MAX    = 8;
    localparam int unsigned DEF_PCNT_WIDTH  = 3;

    function automatic gnt_t other_master(input gnt_t g);
        return (g == GNT_STIM) ? GNT_CHECK : GNT_STIM;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the stim/check engines, the arbiter and the memory port.
//   slave  : arbiter view (takes stim/check requests, drives the memory port)
//   master : engine/memory view (drives requests and memory responses)
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] stim_address;
    logic [BE_WIDTH-1:0]   stim_byteenable;
    logic                  stim_read;
    logic                  stim_waitrequest;
    logic [DATA_WIDTH-1:0] stim_readdata;
    logic                  stim_readdataready;

    logic [ADDR_WIDTH-1:0] check_address;
    logic [BE_WIDTH-1:0]   check_byteenable;
    logic                  check_write;
    logic [DATA_WIDTH-1:0] check_writedata;
    logic                  check_waitrequest;

    logic [ADDR_WIDTH-1:0] mem_address;
    logic [BE_WIDTH-1:0]   mem_byteenable;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] mem_writedata;
    logic                  mem_waitrequest;
    logic [DATA_WIDTH-1:0] mem_readdata;
    logic                  mem_readdataready;

    modport slave (
        input  stim_address, stim_byteenable, stim_read,
        output stim_waitrequest, stim_readdata, stim_readdataready,
        input  check_address, check_byteenable, check_write, check_writedata,
        output check_waitrequest,
        output mem_address, mem_byteenable, mem_read, mem_write, mem_writedata,
        input  mem_waitrequest, mem_readdata, mem_readdataready
    );

    modport master (
        output stim_address, stim_byteenable, stim_read,
        input  stim_waitrequest, stim_readdata, stim_readdataready,
        output check_address, check_byteenable, check_write, check_writedata,
        input  check_waitrequest,
        input  mem_address, mem_byteenable, mem_read, mem_write, mem_writedata,
        output mem_waitrequest, mem_readdata, mem_readdataready
    );

endinterface

// File: rtl/mem_arbiter_rd_tracker.sv
// Outstanding-read tracker for the shared memory port.
//   clock, reset_n : system clock, asynchronous active-low reset
//   acc_r          : a read was accepted by memory this cycle
//   rdready        : memory returned read data this cycle
//   pending        : accepted-but-unreturned reads
//   full           : pending has reached MAX_PENDING
//   proto_err      : sticky, set by a return with nothing outstanding
module rd_tracker
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_PENDING = DEF_MAX_PENDING,
    parameter int unsigned PCNT_WIDTH  = DEF_PCNT_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  acc_r,
    input  logic                  rdready,
    output logic [PCNT_WIDTH-1:0] pending,
    output logic                  full,
    output logic                  proto_err
);
    localparam logic [PCNT_WIDTH-1:0] PMAX = PCNT_WIDTH'(MAX_PENDING);

    assign full = (pending == PMAX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending   <= '0;
            proto_err <= 1'b0;
        end else begin
            if (rdready && (pending == '0)) begin
                proto_err <= 1'b1;
            end
            // A new read and a return in the same cycle cancel out.
            unique case ({acc_r, rdready})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   if (pending != '0) pending <= pending - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single external memory port.
//   clock, reset_n : system clock, asynchronous active-low reset
//   bus            : stim (pipelined reads), check (writes) and memory port
//   pending        : outstanding read count
//   proto_err      : sticky flag, read data returned with nothing outstanding
// Grant is registered (one cycle latency from idle); the memory side is a
// combinational mux on the current grant. An owner stalled by memory keeps
// the bus; otherwise round-robin with a HOLD_MAX burst limit under contention.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned BE_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned MAX_PENDING = DEF_MAX_PENDING,
    parameter int unsigned HOLD_MAX    = DEF_HOLD_MAX,
    parameter int unsigned PCNT_WIDTH  = DEF_PCNT_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    mem_arbiter_if.slave          bus,
    output logic [PCNT_WIDTH-1:0] pending,
    output logic                  proto_err
);
    localparam int unsigned         HCNT_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HCNT_W-1:0]   HOLD_SAT = HCNT_W'(HOLD_MAX);
    localparam logic [HCNT_W:0]     HOLD_LIM = (HCNT_W + 1)'(HOLD_MAX);

    gnt_t              gnt;
    gnt_t              gnt_nxt;
    gnt_t              last;
    logic [HCNT_W-1:0] hold_cnt;
    logic [HCNT_W:0]   hold_sum;

    logic                  full;
    logic                  s_req;
    logic                  c_req;
    logic                  owner_req;
    logic                  locked;
    logic                  acc_r;
    logic                  acc;

    logic [ADDR_WIDTH-1:0] mux_addr;
    logic [BE_WIDTH-1:0]   mux_be;
    logic [DATA_WIDTH-1:0] mux_wd;
    logic                  mux_rd;
    logic                  mux_wr;

    assign s_req = bus.stim_read & ~full;
    assign c_req = bus.check_write;

    always_comb begin
        mux_addr = '0;
        mux_be   = '0;
        mux_wd   = '0;
        mux_rd   = 1'b0;
        mux_wr   = 1'b0;
        unique case (gnt)
            GNT_STIM: begin
                mux_addr = bus.stim_address;
                mux_be   = bus.stim_byteenable;
                mux_rd   = s_req;
            end
            GNT_CHECK: begin
                mux_addr = bus.check_address;
                mux_be   = bus.check_byteenable;
                mux_wd   = bus.check_writedata;
                mux_wr   = c_req;
            end
            default: ;
        endcase
    end

    assign bus.mem_address    = mux_addr;
    assign bus.mem_byteenable = mux_be;
    assign bus.mem_writedata  = mux_wd;
    assign bus.mem_read       = mux_rd;
    assign bus.mem_write      = mux_wr;

    assign bus.stim_waitrequest  = (gnt != GNT_STIM) | bus.mem_waitrequest | full;
    assign bus.check_waitrequest = (gnt != GNT_CHECK) | bus.mem_waitrequest;

    assign bus.stim_readdata      = bus.mem_readdata;
    assign bus.stim_readdataready = bus.mem_readdataready;

    assign acc_r = mux_rd & ~bus.mem_waitrequest;
    assign acc   = (mux_rd | mux_wr) & ~bus.mem_waitrequest;

    assign owner_req = ((gnt == GNT_STIM) & s_req) | ((gnt == GNT_CHECK) & c_req);
    assign locked    = owner_req & bus.mem_waitrequest;
    // Count this cycle's accept so the limit takes effect on the HOLD_MAX-th one.
    assign hold_sum  = {1'b0, hold_cnt} + {{HCNT_W{1'b0}}, acc};

    always_comb begin
        gnt_nxt = gnt;
        if (!locked) begin
            if (s_req && c_req) begin
                if (gnt == GNT_NONE) begin
                    gnt_nxt = other_master(last);
                end else if (hold_sum >= HOLD_LIM) begin
                    gnt_nxt = other_master(gnt);
                end
            end else if (s_req) begin
                gnt_nxt = GNT_STIM;
            end else if (c_req) begin
                gnt_nxt = GNT_CHECK;
            end else begin
                gnt_nxt = GNT_NONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gnt      <= GNT_NONE;
            last     <= GNT_CHECK;
            hold_cnt <= '0;
        end else begin
            gnt <= gnt_nxt;
            if (gnt_nxt != gnt) begin
                hold_cnt <= '0;
                if (gnt_nxt != GNT_NONE) begin
                    last <= gnt_nxt;
                end
            end else if (acc && (hold_cnt != HOLD_SAT)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    rd_tracker #(
        .MAX_PENDING (MAX_PENDING),
        .PCNT_WIDTH  (PCNT_WIDTH)
    ) u_rd_tracker (
        .clock     (clock),
        .reset_n   (reset_n),
        .acc_r     (acc_r),
        .rdready   (bus.mem_readdataready),
        .pending   (pending),
        .full      (full),
        .proto_err (proto_err)
    );

endmodule
